// File: rtl/pano_led_button_ctrl.sv
// pano_led_button_ctrl
// Front-panel button handling (synchronise, debounce, short/long press
// classification) plus a per-channel LED driver offering off, on, a shared
// blink phase and PWM dimming. All state is clocked on SYSCLK.
module pano_led_button_ctrl #(
  parameter int CLK_HZ         = 25000000,
  parameter int TICK_HZ        = 1000,
  parameter int NUM_LEDS       = 3,
  parameter int PWM_BITS       = 4,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 2000,
  parameter int BLINK_TICKS    = 500
) (
  input  logic                         SYSCLK,
  input  logic                         RESET,
  input  logic                         PANO_BUTTON,
  input  logic [2*NUM_LEDS-1:0]        mode,
  input  logic [PWM_BITS*NUM_LEDS-1:0] duty,
  output logic [NUM_LEDS-1:0]          LED_OUT,
  output logic                         button_pressed,
  output logic                         short_press,
  output logic                         boot_req
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W  = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  logic [DIV_W-1:0]   presc_cnt;
  logic               tick;
  logic [1:0]         sync_ff;
  logic               raw_pressed;
  logic               raw_prev;
  logic [DEB_W-1:0]   deb_cnt;
  logic [1:0]         press_state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               long_hit;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign tick        = (presc_cnt == DIV_LAST);
  assign raw_pressed = ~sync_ff[1];
  assign long_hit    = (press_state == ST_HELD) && tick && (hold_cnt == HOLD_LAST);

  // Time-base prescaler: one tick cycle out of every DIV
  always_ff @(posedge SYSCLK) begin
    if (RESET)     presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + DIV_W'(1);
  end

  // Two-flop synchroniser; idles high so a reset looks like a released button
  always_ff @(posedge SYSCLK) begin
    if (RESET) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], PANO_BUTTON};
  end

  // Debounce: accept a new level once it has been steady for DEBOUNCE_TICKS ticks
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      raw_prev       <= 1'b0;
      deb_cnt        <= '0;
      button_pressed <= 1'b0;
    end else begin
      raw_prev <= raw_pressed;
      if (raw_pressed != raw_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        if (raw_pressed != button_pressed) begin
          button_pressed <= raw_pressed;
          deb_cnt        <= '0;
        end
      end else if (tick) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Press classifier; a long press reached on the release cycle still counts as long
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      press_state <= ST_IDLE;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      boot_req    <= 1'b0;
    end else begin
      short_press <= 1'b0;
      boot_req    <= 1'b0;
      case (press_state)
        ST_IDLE: begin
          if (button_pressed) begin
            press_state <= ST_HELD;
            hold_cnt    <= '0;
          end
        end
        ST_HELD: begin
          if (long_hit) begin
            boot_req    <= 1'b1;
            press_state <= button_pressed ? ST_LONG : ST_IDLE;
          end else if (!button_pressed) begin
            short_press <= 1'b1;
            press_state <= ST_IDLE;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (!button_pressed) press_state <= ST_IDLE;
        end
        default: press_state <= ST_IDLE;
      endcase
    end
  end

  // Free-running blink phase shared by every channel
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // PWM reference counter, advancing every clock and wrapping naturally
  always_ff @(posedge SYSCLK) begin
    if (RESET) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Registered LED drive selected per channel by its mode field
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      LED_OUT <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        case (mode[2*i +: 2])
          2'b00:   LED_OUT[i] <= 1'b0;
          2'b01:   LED_OUT[i] <= 1'b1;
          2'b10:   LED_OUT[i] <= blink_phase;
          default: LED_OUT[i] <= (pwm_cnt < duty[PWM_BITS*i +: PWM_BITS]);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pano_led_button_ctrl.sv
// tb_pano_led_button_ctrl
// Drives directed and random button/mode traffic into pano_led_button_ctrl and
// compares every output on every cycle against a timeline-based model.
module tb_pano_led_button_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DEB     = 2;
  localparam int LONG    = 10;
  localparam int BLINK   = 3;
  localparam int NL      = 3;
  localparam int PB      = 2;

  logic           SYSCLK = 1'b0;
  logic           RESET = 1'b1;
  logic           PANO_BUTTON = 1'b1;
  logic [2*NL-1:0]  mode = '0;
  logic [PB*NL-1:0] duty = '0;
  logic [NL-1:0]  LED_OUT;
  logic           button_pressed;
  logic           short_press;
  logic           boot_req;

  int compared = 0;
  int mismatched = 0;

  // model state: k is the index of the next non-reset clock edge
  int   k = 0;
  int   stable_from = 0;
  logic bp_m = 1'b0;
  logic raw_last = 1'b0;
  logic hist1 = 1'b1;
  logic hist2 = 1'b1;
  bit   press_active = 1'b0;
  bit   long_fired = 1'b0;
  int   press_from = 0;
  logic [NL-1:0] exp_led = '0;
  logic exp_short = 1'b0;
  logic exp_boot = 1'b0;

  // observed activity, used by the hand-computed checks
  int   short_seen = 0;
  int   boot_seen = 0;
  int   rises_seen = 0;
  int   rise_at = 0;
  logic bp_seen_last = 1'b0;

  pano_led_button_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_LEDS(NL), .PWM_BITS(PB),
    .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LONG), .BLINK_TICKS(BLINK)
  ) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .PANO_BUTTON(PANO_BUTTON),
    .mode(mode), .duty(duty), .LED_OUT(LED_OUT),
    .button_pressed(button_pressed), .short_press(short_press), .boot_req(boot_req)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic btn, input logic rst, input int cycles);
    PANO_BUTTON = btn;
    RESET = rst;
    repeat (cycles) @(posedge SYSCLK);
    #2;
  endtask

  // number of ticks falling in cycles a..b inclusive (tick on cycle c when c%DIV==DIV-1)
  function automatic int ticks_in(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / DIV - a / DIV;
  endfunction

  function automatic bit is_tick(input int c);
    return (c % DIV) == DIV - 1;
  endfunction

  // Reference model: what each output must show after edge k, from the raw timeline
  always @(posedge SYSCLK) begin
    logic raw;
    int   stable;
    if (RESET) begin
      k = 0; stable_from = 0; bp_m = 1'b0; raw_last = 1'b0;
      hist1 = 1'b1; hist2 = 1'b1;
      press_active = 1'b0; long_fired = 1'b0; press_from = 0;
      exp_led = '0; exp_short = 1'b0; exp_boot = 1'b0;
    end else begin
      raw = ~hist2;
      exp_short = 1'b0;
      exp_boot  = 1'b0;
      if (!press_active) begin
        if (bp_m) begin
          press_active = 1'b1;
          long_fired   = 1'b0;
          press_from   = k + 1;
        end
      end else if (!long_fired) begin
        if (is_tick(k) && ticks_in(press_from, k) == LONG) begin
          exp_boot   = 1'b1;
          long_fired = 1'b1;
          if (!bp_m) press_active = 1'b0;
        end else if (!bp_m) begin
          exp_short    = 1'b1;
          press_active = 1'b0;
        end
      end else if (!bp_m) begin
        press_active = 1'b0;
      end
      if (raw != raw_last) begin
        stable_from = k + 1;
      end else begin
        stable = ticks_in(stable_from, k - 1);
        if (stable > DEB) stable = DEB;
        if (stable == DEB && raw != bp_m) begin
          bp_m        = raw;
          stable_from = k + 1;
        end
      end
      raw_last = raw;
      for (int i = 0; i < NL; i++) begin
        case (mode[2*i +: 2])
          2'b00:   exp_led[i] = 1'b0;
          2'b01:   exp_led[i] = 1'b1;
          2'b10:   exp_led[i] = 1'(((k / DIV) / BLINK) % 2);
          default: exp_led[i] = ((k % (1 << PB)) < int'(duty[PB*i +: PB]));
        endcase
      end
      hist2 = hist1;
      hist1 = PANO_BUTTON;
      k++;
    end
  end

  // Compare every output against the model once per cycle, away from the edge
  always @(negedge SYSCLK) begin
    checkOutput("led_out", 32'(LED_OUT), 32'(exp_led));
    checkOutput("button_pressed", 32'(button_pressed), 32'(bp_m));
    checkOutput("short_press", 32'(short_press), 32'(exp_short));
    checkOutput("boot_req", 32'(boot_req), 32'(exp_boot));
    if (short_press === 1'b1) short_seen++;
    if (boot_req === 1'b1) boot_seen++;
    if (button_pressed === 1'b1 && bp_seen_last !== 1'b1) begin
      rises_seen++;
      rise_at = k;
    end
    bp_seen_last = button_pressed;
  end

  initial begin
    int sh0, bo0, ri0, p;
    int c0, c1, c2;

    // reset, then idle with channels off / on / blink
    mode = 6'b10_01_00;
    duty = '0;
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("reset_led", 32'(LED_OUT), 32'd0);
    checkOutput("reset_button_pressed", 32'(button_pressed), 32'd0);
    checkOutput("reset_short", 32'(short_press), 32'd0);
    checkOutput("reset_boot", 32'(boot_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("idle_first_edge", 32'(LED_OUT), 32'b010);
    applyStimulus(1'b1, 1'b0, 29);
    checkOutput("blink_dark_edge29", 32'(LED_OUT), 32'b010);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("blink_lit_edge30", 32'(LED_OUT), 32'b110);
    applyStimulus(1'b1, 1'b0, 30);
    checkOutput("blink_dark_edge60", 32'(LED_OUT), 32'b010);

    // pressed level broken by 3-cycle glitches every 8 cycles never qualifies
    sh0 = short_seen; bo0 = boot_seen; ri0 = rises_seen;
    for (int n = 0; n < 25; n++) begin
      applyStimulus(1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 3);
    end
    applyStimulus(1'b1, 1'b0, 40);
    checkOutput("glitch_no_accept", 32'(rises_seen - ri0), 32'd0);
    checkOutput("glitch_no_short", 32'(short_seen - sh0), 32'd0);
    checkOutput("glitch_no_boot", 32'(boot_seen - bo0), 32'd0);

    // clean short press after a long quiet period
    applyStimulus(1'b1, 1'b0, 500);
    sh0 = short_seen; bo0 = boot_seen;
    p = k;
    applyStimulus(1'b0, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("press_rise_window", 32'((rise_at - p >= 10) && (rise_at - p <= 30)), 32'd1);
    checkOutput("short_count", 32'(short_seen - sh0), 32'd1);
    checkOutput("short_no_boot", 32'(boot_seen - bo0), 32'd0);

    // long hold: one boot request, no short press on release
    sh0 = short_seen; bo0 = boot_seen;
    applyStimulus(1'b0, 1'b0, 300);
    checkOutput("long_boot_once", 32'(boot_seen - bo0), 32'd1);
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("long_no_short", 32'(short_seen - sh0), 32'd0);
    checkOutput("long_boot_still_once", 32'(boot_seen - bo0), 32'd1);

    // PWM duty 0/1/3 on channels 0/1/2 over two full periods
    mode = 6'b11_11_11;
    duty = {2'd3, 2'd1, 2'd0};
    applyStimulus(1'b1, 1'b0, 2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int n = 0; n < 8; n++) begin
      c0 += int'(LED_OUT[0]);
      c1 += int'(LED_OUT[1]);
      c2 += int'(LED_OUT[2]);
      applyStimulus(1'b1, 1'b0, 1);
    end
    checkOutput("pwm_duty0_lit", 32'(c0), 32'd0);
    checkOutput("pwm_duty1_lit", 32'(c1), 32'd2);
    checkOutput("pwm_duty3_lit", 32'(c2), 32'd6);

    // reset in the middle of a held press aborts it; the hold must requalify
    sh0 = short_seen; bo0 = boot_seen;
    applyStimulus(1'b0, 1'b0, 50);
    checkOutput("held_before_reset", 32'(button_pressed), 32'd1);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("reset_mid_led", 32'(LED_OUT), 32'd0);
    checkOutput("reset_mid_button", 32'(button_pressed), 32'd0);
    ri0 = rises_seen;
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("post_reset_button", 32'(button_pressed), 32'd0);
    checkOutput("post_reset_no_short", 32'(short_seen - sh0), 32'd0);
    checkOutput("post_reset_no_boot", 32'(boot_seen - bo0), 32'd0);
    applyStimulus(1'b0, 1'b0, 57);
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("requalify_rise", 32'(rises_seen - ri0), 32'd1);
    checkOutput("requalify_short", 32'(short_seen - sh0), 32'd1);
    checkOutput("requalify_no_boot", 32'(boot_seen - bo0), 32'd0);

    // random traffic, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      mode = 6'($urandom);
      duty = 6'($urandom);
      case ($urandom_range(0, 4))
        0, 1: applyStimulus(1'($urandom), 1'b0, int'($urandom_range(1, 40)));
        2:    applyStimulus(1'b0, 1'b0, int'($urandom_range(90, 160)));
        3: begin
          repeat ($urandom_range(2, 6)) applyStimulus(~PANO_BUTTON, 1'b0, int'($urandom_range(1, 6)));
        end
        default: begin
          applyStimulus(PANO_BUTTON, 1'b1, int'($urandom_range(1, 3)));
          applyStimulus(PANO_BUTTON, 1'b0, int'($urandom_range(1, 20)));
        end
      endcase
    end
    applyStimulus(1'b1, 1'b0, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pano_led_button_ctrl.md
PANO_LED_BUTTON_CTRL -- requirements
Module: pano_led_button_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 25000000, SYSCLK frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, internal time-base rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 Parameter NUM_LEDS, default 3, LED channel count, 1..16.
REQ-004 Parameter PWM_BITS, default 4, per-channel duty width, 1..8.
REQ-005 Parameter DEBOUNCE_TICKS, default 20, ticks a new button level must be stable before acceptance, >= 1.
REQ-006 Parameter LONG_TICKS, default 2000, held ticks that qualify a long press, > DEBOUNCE_TICKS.
REQ-007 Parameter BLINK_TICKS, default 500, ticks per blink half-period, >= 1.
REQ-008 SYSCLK  input  1  sole clock; all state updates on rising edge.
REQ-009 RESET  input  1  synchronous, active-high reset.
REQ-010 PANO_BUTTON  input  1  raw asynchronous button, low = pressed.
REQ-011 mode  input  2*NUM_LEDS  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 pwm.
REQ-012 duty  input  PWM_BITS*NUM_LEDS  per-channel PWM duty, channel i at [PWM_BITS*(i+1)-1:PWM_BITS*i].
REQ-013 LED_OUT  output  NUM_LEDS  registered LED drive, 1 = lit.
REQ-014 button_pressed  output  1  debounced level, 1 = pressed.
REQ-015 short_press  output  1  one-cycle pulse per qualifying short press.
REQ-016 boot_req  output  1  one-cycle pulse per long press; intended to drive the multiboot trigger.

Function
REQ-017 Prescaler counts 0..DIV-1 and wraps; internal tick asserted for exactly the one cycle the count equals DIV-1.
REQ-018 PANO_BUTTON passes a 2-flop synchronizer; synchronized level inverted gives raw_pressed.
REQ-019 Debounce: stability counter cleared on any cycle raw_pressed differs from its prior-cycle value; incremented per tick otherwise; when it reaches DEBOUNCE_TICKS with raw_pressed != button_pressed, button_pressed takes raw_pressed and counter clears.
REQ-020 Press FSM states IDLE, HELD, LONG; hold counter increments per tick in HELD only.
REQ-021 IDLE -> HELD on button_pressed 0->1 (hold counter cleared).
REQ-022 HELD -> IDLE on button_pressed 1->0 with short_press pulsed that cycle.
REQ-023 HELD -> LONG when hold counter reaches LONG_TICKS, boot_req pulsed that cycle; release no longer produces short_press.
REQ-024 LONG -> IDLE on release, no pulse; a continued hold never re-pulses boot_req.
REQ-025 Release and long-threshold in the same cycle: long wins (boot_req, no short_press, FSM to IDLE).
REQ-026 short_press and boot_req never asserted in the same cycle, never longer than one cycle.
REQ-027 Blink phase register toggles every BLINK_TICKS ticks, shared by all channels, free-running.
REQ-028 PWM counter of PWM_BITS advances every SYSCLK cycle, wraps 2^PWM_BITS-1 -> 0; pwm-mode channel lit iff counter < duty (duty 0 = always dark, max duty = dark one cycle per period).
REQ-029 LED_OUT[i] registered from mode/phase/PWM: one-cycle latency from a mode or duty change to LED_OUT.
REQ-030 Counter widths sized from parameters via clog2; no counter overflows for any legal parameter set.

Reset
REQ-031 RESET held high: LED_OUT = 0, button_pressed = 0, short_press = 0, boot_req = 0, FSM IDLE, all counters 0, blink phase 0, synchronizer flops 1 (released).
REQ-032 RESET mid-press aborts the press silently: no pulse on reset or first post-reset cycle; a still-held button is re-debounced from scratch.

Verification (sim params CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_TICKS=2, LONG_TICKS=10, BLINK_TICKS=3, NUM_LEDS=3, PWM_BITS=2)
REQ-033 Reset then idle: tick every 10 cycles; blink-mode LED toggles every 30 cycles starting dark; mode 00/01 LEDs steady 0/1.
REQ-034 Button low with 3-cycle glitches every 8 cycles for 200 cycles -> button_pressed stays 0, no pulses.
REQ-035 Clean press 50 ticks after stable then release -> button_pressed rises ~2-3 ticks after press; single short_press on release; boot_req 0.
REQ-036 Hold 300 cycles -> exactly one boot_req ~10 ticks after debounce acceptance; release -> no short_press.
REQ-037 pwm mode, duty=0/1/3 on channels 0/1/2 -> LED_OUT high 0/1/3 of every 4 cycles.
REQ-038 RESET pulsed during HELD -> all outputs 0 next cycle, no short_press/boot_req, re-qualification required.
